// File: rtl/um_waves.sv
// UART-controlled waveform generator: an 8N1 receiver decodes ASCII commands that pick
// a waveform and, when WAVES_NOISE_EN is defined, toggle additive LFSR noise on the sample.
module um_waves #(
  parameter int CLK_HZ       = 25_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int TICK_DIV     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] uo_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [15:0]      TICK_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  function automatic logic [7:0] wave_gen(input logic [2:0] sel, input logic [7:0] ph);
    logic [7:0] w;
    case (sel)
      3'b001:  w = ph;
      3'b010:  w = {8{ph[7]}};
      3'b011:  w = ~ph;
      default: w = ph[7] ? {~ph[6:0], 1'b0} : {ph[6:0], 1'b0};
    endcase
    return w;
  endfunction

  function automatic logic [7:0] add_noise(input logic [7:0] w, input logic [3:0] n);
    return w ^ {4'b0000, n};
  endfunction

  logic       rx_meta, rx_sync;
  rx_state_t  state;
  logic [CNT_W-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic [2:0] wave_sel;
  logic       noise_en;
  logic [15:0] tick_cnt;
  logic [7:0] p;
  logic [7:0] wave_p0;

  // Stage: rx synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Stage: receiver control; a stop bit of 0 drops the byte silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_sync) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            state      <= IDLE;
            byte_valid <= rx_sync;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Receiver datapath: LSB-first shift at bit centres, captured when the stop bit is good
  always_ff @(posedge clk) begin
    if (state == DATA && cnt == BIT_LAST) shreg <= {rx_sync, shreg[7:1]};
    if (state == STOP && cnt == BIT_LAST && rx_sync) rx_byte <= shreg;
  end

  // Stage: command decode
`ifdef WAVES_NOISE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_sel <= 3'b000;
      noise_en <= 1'b0;
    end else if (byte_valid) begin
      case (rx_byte)
        8'h54:   wave_sel <= 3'b000;
        8'h53:   wave_sel <= 3'b001;
        8'h51:   wave_sel <= 3'b010;
        8'h52:   wave_sel <= 3'b011;
        8'h4E:   noise_en <= 1'b1;
        8'h46:   noise_en <= 1'b0;
        default: ;
      endcase
    end
  end
`else
  assign noise_en = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_sel <= 3'b000;
    end else if (byte_valid) begin
      case (rx_byte)
        8'h54:   wave_sel <= 3'b000;
        8'h53:   wave_sel <= 3'b001;
        8'h51:   wave_sel <= 3'b010;
        8'h52:   wave_sel <= 3'b011;
        default: ;
      endcase
    end
  end
`endif

  // Stage: phase accumulator, free-running and untouched by commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      p        <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      p        <= p + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign wave_p0 = wave_gen(wave_sel, p);

  // Stage: output register, optional noise on the low nibble
`ifdef WAVES_NOISE_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'h01;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        uo_out <= 8'h00;
    else if (noise_en) uo_out <= add_noise(wave_p0, lfsr[3:0]);
    else               uo_out <= wave_p0;
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uo_out <= 8'h00;
    else        uo_out <= (noise_en ? add_noise(wave_p0, 4'h0) : wave_p0);
  end
`endif

endmodule

// File: tb/tb_um_waves.sv
// Scoreboard bench for um_waves: expected samples are queued per cycle index when a
// mode window opens, and a negedge monitor pops and compares them against uo_out.
module tb_um_waves;

  localparam int CPB = 16;
`ifdef WAVES_NOISE_EN
  localparam bit NZ = 1'b1;
`else
  localparam bit NZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] uo_out;

  um_waves #(
    .CLK_HZ(153_600), .BAUD(9600), .CLKS_PER_BIT(CPB), .TICK_DIV(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .uo_out(uo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic [7:0] lfsr_seq[255];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      tests++;
      if (mon_e.cyc != cyc) begin
        fails++;
        $display("FAIL %s: cycle %0d check missed, now cycle %0d", mon_e.tag, mon_e.cyc, cyc);
      end else if (uo_out !== mon_e.val) begin
        fails++;
        $display("FAIL %s: cycle %0d uo_out=%02h expected %02h", mon_e.tag, cyc, uo_out, mon_e.val);
      end
    end
  end

  // Expected sample after edge c: mode applied to phase c-1, noise from LFSR state c-1
  function automatic logic [7:0] exp_val(input int c, input int mode, input bit nz);
    logic [7:0] ph;
    logic [7:0] w;
    ph = 8'((c - 1) % 256);
    case (mode)
      1:       w = ph;
      2:       w = ph[7] ? 8'hFF : 8'h00;
      3:       w = 8'hFF - ph;
      default: w = (ph < 8'd128) ? 8'(ph * 2) : 8'((255 - ph) * 2);
    endcase
    if (nz) w = w ^ {4'h0, lfsr_seq[(c - 1) % 255][3:0]};
    return w;
  endfunction

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_window(input int n, input int mode, input bit nz, input string tag);
    for (int i = 1; i <= n; i++) begin
      exp_t e;
      e.cyc = cyc + i;
      e.val = exp_val(cyc + i, mode, nz);
      e.tag = tag;
      q.push_back(e);
    end
    hold(n + 2);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(CPB);
    end
    if (good_stop) begin
      rx = 1'b1;
      hold(CPB);
    end else begin
      rx = 1'b0;
      hold(CPB * 3 / 4);
      rx = 1'b1;
      hold(CPB / 4);
    end
    hold(2 * CPB);
  endtask

  initial begin
    lfsr_seq[0] = 8'h01;
    for (int i = 1; i < 255; i++)
      lfsr_seq[i] = {lfsr_seq[i-1][6:0],
                     lfsr_seq[i-1][7] ^ lfsr_seq[i-1][5] ^ lfsr_seq[i-1][4] ^ lfsr_seq[i-1][3]};

    rst_n = 1'b0;
    begin
      exp_t e;
      e.cyc = 0; e.val = 8'h00; e.tag = "reset";
      q.push_back(e);
    end
    #102;
    rst_n = 1'b1;
    expect_window(20, 0, 1'b0, "ramp_after_reset");

    send_byte(8'h54, 1'b1);
    expect_window(40, 0, 1'b0, "tri_T");
    send_byte(8'h4E, 1'b1);
    expect_window(40, 0, NZ, "noise_N");
    send_byte(8'h46, 1'b1);
    expect_window(40, 0, 1'b0, "noise_F");
    send_byte(8'h51, 1'b1);
    expect_window(300, 2, 1'b0, "square_Q");
    send_byte(8'h53, 1'b1);
    expect_window(30, 1, 1'b0, "saw_S");
    send_byte(8'h78, 1'b1);
    expect_window(30, 1, 1'b0, "ignore_x");
    send_byte(8'h52, 1'b1);
    expect_window(30, 3, 1'b0, "rsaw_R");
    send_byte(8'h54, 1'b0);
    expect_window(30, 3, 1'b0, "bad_stop");

    rx = 1'b0;
    hold(3);
    rx = 1'b1;
    hold(2 * CPB);
    expect_window(30, 3, 1'b0, "glitch");

    rx = 1'b0;
    hold(30 * CPB);
    rx = 1'b1;
    hold(12 * CPB);
    expect_window(30, 3, 1'b0, "break");

    send_byte(8'h53, 1'b1);
    send_byte(8'h4E, 1'b1);
    expect_window(40, 1, NZ, "saw_noise");

    // Partial 'T' frame, then asynchronous reset in the middle of it
    rx = 1'b0;
    hold(CPB);
    rx = 1'b0;
    hold(CPB);
    rx = 1'b0;
    hold(CPB);
    rx = 1'b1;
    hold(CPB / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    begin
      exp_t e;
      e.cyc = 0; e.val = 8'h00; e.tag = "reset_mid_frame";
      q.push_back(e);
    end
    #20;
    rst_n = 1'b1;
    expect_window(20, 0, 1'b0, "ramp_after_mid_reset");
    hold(12 * CPB);
    expect_window(20, 0, 1'b0, "no_partial_decode");

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d checks pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t reached, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
